seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range WIDTH >= 2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 A  input  WIDTH  operand A.
REQ-005 B  input  WIDTH  operand B.
REQ-006 op  input  3  opcode: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 INC (A+1), 110 MOV (A), 111 MUL (A*B, low WIDTH bits, unsigned).
REQ-007 in_valid  input  1  request valid.
REQ-008 in_ready  output  1  block can accept a request; high only in IDLE.
REQ-009 Y  output  WIDTH  registered result.
REQ-010 ONZ  output  3  registered flags: [2] O overflow, [1] N = Y[WIDTH-1], [0] Z = (Y == 0).
REQ-011 out_valid  output  1  Y/ONZ hold a result not yet consumed.
REQ-012 out_ready  input  1  consumer accepts the result.

Function
REQ-013 States: IDLE, BUSY, DONE; accept = in_valid & in_ready; A, B and op are captured at accept.
REQ-014 IDLE: on accept with op != 111, go to DONE and load Y/ONZ, so out_valid is high the cycle after accept (latency 1).
REQ-015 IDLE: on accept with op == 111, go to BUSY; iterative shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY; Y/ONZ load on the last BUSY cycle, so out_valid rises WIDTH+1 cycles after accept.
REQ-016 BUSY ignores in_valid, A, B, op; in_ready = 0.
REQ-017 DONE: out_valid = 1; Y/ONZ hold stable; on out_ready go to IDLE, with out_valid = 0 the next cycle.
REQ-018 in_ready = 0 in DONE; no request is accepted in the same cycle that out_ready completes.
REQ-019 Arithmetic wraps modulo 2^WIDTH.
REQ-020 O for ADD/SUB/INC: two's-complement signed overflow (INC: A = 0 followed by WIDTH-1 ones).
REQ-021 O for MUL: set when the upper WIDTH bits of the full 2*WIDTH product are nonzero.
REQ-022 O = 0 for AND/OR/XOR/MOV.
REQ-023 N and Z are always derived from the final Y.
REQ-024 Operand registers are internal; changing A/B/op after accept does not affect the result.

Reset
REQ-025 rst asserted at any time, including mid-BUSY or in DONE, immediately forces state = IDLE, Y = 0, ONZ = 000, out_valid = 0, and clears multiplier state.
REQ-026 in_ready = 1 while in IDLE, including during reset and from the first cycle after reset deasserts.

Configuration
REQ-027 Macro SEQ_ALU_MUL_EN defined: MUL and BUSY state present, per REQ-015/REQ-021.
REQ-028 Macro SEQ_ALU_MUL_EN undefined: no BUSY state or multiplier logic; op 111 completes with latency 1, Y = 0, ONZ = 001.

Verification (WIDTH = 8, SEQ_ALU_MUL_EN defined unless stated)
REQ-029 ADD A=7F, B=01 -> Y=80, ONZ=110, out_valid exactly 1 cycle after accept; SUB A=05, B=05 -> Y=00, ONZ=001.
REQ-030 MUL A=15, B=17 (decimal) -> Y=FF, ONZ=010 at 9 cycles after accept; MUL A=16, B=16 -> Y=00, ONZ=101; in_ready low throughout BUSY.
REQ-031 Backpressure: INC A=7F with out_ready held low for 3 cycles -> Y=80, ONZ=110 stable, out_valid high, in_ready low; out_ready=1 -> IDLE next cycle.
REQ-032 Reset pulse 4 cycles into a MUL -> Y=00, ONZ=000, out_valid=0 immediately; in_ready=1; a following ADD 02+03 returns Y=05.
REQ-033 Operand change: ADD A=01, B=01 accepted, then A/B changed to FF the next cycle -> Y=02.
REQ-034 SEQ_ALU_MUL_EN undefined: op 111, A=03, B=03 -> Y=00, ONZ=001, latency 1.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes and registered Y/ONZ outputs.
// Optional iterative shift-add multiplier (op 111) enabled by SEQ_ALU_MUL_EN.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y,
    output logic [2:0]       ONZ,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_INC = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;

`ifdef SEQ_ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b111;
    localparam int         CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_DONE
    } state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] y_q;
    logic [2:0]       onz_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic [WIDTH-1:0] alu_y;
    logic             alu_o;

    // Single-cycle result of the current request, used only at accept.
    always_comb begin
        alu_y = '0;
        alu_o = 1'b0;
        case (op)
            OP_ADD: begin
                alu_y = A + B;
                alu_o = (A[MSB] == B[MSB]) && (alu_y[MSB] != A[MSB]);
            end
            OP_SUB: begin
                alu_y = A - B;
                alu_o = (A[MSB] != B[MSB]) && (alu_y[MSB] != A[MSB]);
            end
            OP_AND: alu_y = A & B;
            OP_OR:  alu_y = A | B;
            OP_XOR: alu_y = A ^ B;
            OP_INC: begin
                alu_y = A + {{(WIDTH-1){1'b0}}, 1'b1};
                alu_o = (A == {1'b0, {(WIDTH-1){1'b1}}});
            end
            OP_MOV: alu_y = A;
            // op 111 without the multiplier yields zero with no overflow.
            default: begin
                alu_y = '0;
                alu_o = 1'b0;
            end
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    // Partial product after folding in the current multiplier bit.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end
`endif

    // Control FSM; all outputs and multiplier state are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            y_q         <= '0;
            onz_q       <= 3'b000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef SEQ_ALU_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
                        if (op == OP_MUL) begin
                            state_q  <= S_BUSY;
                            acc_q    <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, A};
                            mplier_q <= B;
                            cnt_q    <= '0;
                        end else begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            y_q         <= alu_y;
                            onz_q       <= {alu_o, alu_y[MSB], alu_y == '0};
                        end
`else
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        y_q         <= alu_y;
                        onz_q       <= {alu_o, alu_y[MSB], alu_y == '0};
`endif
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                S_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        y_q         <= acc_d[WIDTH-1:0];
                        onz_q       <= {|acc_d[2*WIDTH-1:WIDTH],
                                        acc_d[MSB],
                                        acc_d[WIDTH-1:0] == '0};
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Y         = y_q;
    assign ONZ       = onz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic model.
// Expectations for op 111 follow whether SEQ_ALU_MUL_EN is defined.
module tb_seq_alu;

    localparam int W = 8;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN  = 1'b1;
    localparam int MUL_LAT = W + 1;
`else
    localparam bit MUL_EN  = 1'b0;
    localparam int MUL_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   op = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] Y;
    logic [2:0]   ONZ;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int busy_ready_seen;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .ONZ       (ONZ),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference: signed overflow from integer range, MUL from full product.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] y,
                                  output logic [2:0] onz);
        int ia, ib, sa, sb, r, p;
        logic ov;
        ia = int'(a);
        ib = int'(b);
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        ov = 1'b0;
        y  = '0;
        case (o)
            3'd0: begin r = sa + sb; y = 8'(ia + ib); ov = (r > 127) || (r < -128); end
            3'd1: begin r = sa - sb; y = 8'(ia - ib); ov = (r > 127) || (r < -128); end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: begin r = sa + 1; y = 8'(ia + 1); ov = (r > 127); end
            3'd6: y = a;
            default: begin
                if (MUL_EN) begin
                    p  = ia * ib;
                    y  = 8'(p);
                    ov = (p > 255);
                end
            end
        endcase
        onz = {ov, y[W-1], (y == 0)};
    endfunction

    // Issue one request; returns the result and cycles from accept to out_valid.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] post,
                         output logic [W-1:0] y, output logic [2:0] onz,
                         output int lat);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        A = a;
        B = b;
        op = o;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = post;
        B = post;
        op = 3'($urandom);
        lat = 1;
        busy_ready_seen = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ready_seen++;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        y = Y;
        onz = ONZ;
    endtask

    // Hand the result back and land one cycle later in IDLE.
    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({Y, ONZ, out_valid, in_ready} !== {8'h00, 3'b000, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_hold: Y=%h ONZ=%b ov=%b ir=%b want 00 000 0 1",
                     Y, ONZ, out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic check_op(input string nm, input logic [2:0] o,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] post);
        logic [W-1:0] y, ey;
        logic [2:0] onz, eonz;
        int lat, elat;
        model(o, a, b, ey, eonz);
        elat = (o == 3'b111) ? MUL_LAT : 1;
        do_op(o, a, b, post, y, onz, lat);
        n_cmp++;
        if ({y, onz} !== {ey, eonz}) begin
            n_err++;
            $display("FAIL %s: op=%0d a=%h b=%h got Y=%h ONZ=%b want Y=%h ONZ=%b",
                     nm, o, a, b, y, onz, ey, eonz);
        end
        n_cmp++;
        if (lat !== elat) begin
            n_err++;
            $display("FAIL %s_latency: got %0d want %0d", nm, lat, elat);
        end
        n_cmp++;
        if (busy_ready_seen !== 0) begin
            n_err++;
            $display("FAIL %s_busy_ready: in_ready high %0d cycles, want 0",
                     nm, busy_ready_seen);
        end
        consume();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL %s_release: ov=%b ir=%b want ov=0 ir=1",
                     nm, out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        check_op("add_7f_01", 3'd0, 8'h7F, 8'h01, 8'h00);
        check_op("sub_05_05", 3'd1, 8'h05, 8'h05, 8'h00);
        check_op("mul_15_17", 3'd7, 8'd15, 8'd17, 8'h00);
        check_op("mul_16_16", 3'd7, 8'd16, 8'd16, 8'h00);
        check_op("mul_3_3", 3'd7, 8'h03, 8'h03, 8'h00);
        check_op("sub_80_01", 3'd1, 8'h80, 8'h01, 8'h00);
        check_op("inc_ff", 3'd5, 8'hFF, 8'h00, 8'h00);
    endtask

    task automatic test_operand_change();
        check_op("opchange_add", 3'd0, 8'h01, 8'h01, 8'hFF);
        check_op("opchange_mul", 3'd7, 8'h0B, 8'h0D, 8'hFF);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] y;
        logic [2:0] onz;
        int lat;
        do_op(3'd5, 8'h7F, 8'h00, 8'h00, y, onz, lat);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({Y, ONZ, out_valid, in_ready} !== {8'h80, 3'b110, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL backpressure_hold%0d: Y=%h ONZ=%b ov=%b ir=%b want 80 110 1 0",
                         i, Y, ONZ, out_valid, in_ready);
            end
        end
        consume();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL backpressure_release: ov=%b ir=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        A = 8'd15;
        B = 8'd17;
        op = 3'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({Y, ONZ, out_valid, in_ready} !== {8'h00, 3'b000, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_mid: Y=%h ONZ=%b ov=%b ir=%b want 00 000 0 1",
                     Y, ONZ, out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        check_op("after_reset_add", 3'd0, 8'h02, 8'h03, 8'h00);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            check_op("rand", 3'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_operand_change();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
